mul: RTL and testbench

MUL -- requirements
Module: mul

---
 rtl/mul.sv | 69 ++++++
 tb/tb_mul.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mul.sv
// Two-stage pipelined 32x32 multiplier keeping only the low 32 result bits.
// Define MUL_POWER_PINS_EN to add the VPWR/VGND power-pin ports after C.
module mul (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MUL_POWER_PINS_EN
  output logic [31:0] C,
  inout  wire         VPWR,
  inout  wire         VGND
`else
  output logic [31:0] C
`endif
);

  logic [15:0] w_al;
  logic [15:0] w_ah;
  logic [15:0] w_bl;
  logic [15:0] w_bh;
  logic [31:0] w_sum;

  logic        r_armed;
  logic [31:0] r_ll;
  logic [31:0] r_lh;
  logic [31:0] r_hl;
  logic [31:0] r_c;

  assign w_al = A[15:0];
  assign w_ah = A[31:16];
  assign w_bl = B[15:0];
  assign w_bh = B[31:16];

  // The first edge after reset release only arms the pipeline, so a release
  // landing on a clock edge can never capture operands on that same edge.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // AH*BH only contributes to bits 63:32, so it is never formed.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_ll <= 32'd0;
      r_lh <= 32'd0;
      r_hl <= 32'd0;
    end else if (r_armed) begin
      r_ll <= 32'(w_al) * 32'(w_bl);
      r_lh <= 32'(w_al) * 32'(w_bh);
      r_hl <= 32'(w_ah) * 32'(w_bl);
    end
  end

  assign w_sum = r_ll + ((r_lh + r_hl) << 16);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= 32'd0;
    end else begin
      r_c <= w_sum;
    end
  end

  assign C = r_c;

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: the driver queues one expected result per clock,
// and a monitor compares C against it once the two-cycle latency has elapsed.
module tb_mul;

  logic        CLK;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] C;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] expQ[$];

  mul dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .C    (C)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = 64'(a) * 64'(b);
    return full[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One queue entry per rising edge: the product the pair on A/B should yield.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    expQ.push_back(refMul(a, b));
  endtask

  // Reset asserted between edges; in-flight work is gone and C clears at once.
  task automatic applyReset(input int holdCycles);
    @(negedge CLK);
    #3;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async_reset_clear", C, 32'd0);
    repeat (holdCycles) @(negedge CLK);
    rst_n = 1'b1;
    // The first edge after release does not capture operands.
    expQ.push_back(32'd0);
  endtask

  // Monitor: while in reset C must be 0; otherwise compare against the entry
  // queued two edges earlier, and expect 0 while the pipeline is still filling.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (!rst_n) begin
        checkOutput("reset_hold", C, 32'd0);
      end else if (expQ.size() >= 2) begin
        checkOutput("pipeline_result", C, expQ.pop_front());
      end else begin
        checkOutput("pipeline_fill", C, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    A = 32'd5;
    B = 32'd7;
    #1;
    checkOutput("power_on_reset", C, 32'd0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    expQ.push_back(32'd0);

    applyStimulus(32'd5, 32'd7);

    for (int i = 1; i <= 10; i++) begin
      for (int j = 1; j <= 10; j++) begin
        applyStimulus(32'(i), 32'(j));
      end
    end

    applyStimulus(32'hFFFF_FFFF, 32'd2);
    applyStimulus(32'h0001_0000, 32'h0001_0000);
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(32'h0000_0000, 32'hFFFF_FFFF);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);

    applyStimulus(32'd3, 32'd4);
    applyStimulus(32'd6, 32'd7);
    applyStimulus(32'h0000_FFFF, 32'h0000_FFFF);

    for (int k = 0; k < 150; k++) begin
      applyStimulus($urandom, $urandom);
    end

    applyReset(2);

    applyStimulus(32'd9, 32'd11);
    for (int k = 0; k < 100; k++) begin
      applyStimulus($urandom, $urandom);
    end

    applyStimulus(32'hDEAD_BEEF, 32'hCAFE_F00D);
    applyReset(1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus($urandom, $urandom_range(0, 65535));
    end

    repeat (3) applyStimulus(32'd0, 32'd0);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
